operand_fetch: RTL and testbench

Issue/operand-fetch stage of the nyakuo core, directly upstream of `alu`. It accepts decoded instructions and reads rs1/rs2 from the integer register file. It resolves RAW/WAW hazards with a per-register busy scoreboard and bypasses same-cycle writeback data. It then registers `{inst, operand_a, operand_b, rd}` into a single-entry valid/ready output slot that feeds the ALU.

---
 rtl/nyakuo_pkg.sv | 16 +
 rtl/operand_fetch_regfile.sv | 28 ++
 rtl/operand_fetch.sv | 75 +++++++
 tb/tb_operand_fetch.sv | 137 +++++++++++++
 4 files changed

// File: rtl/nyakuo_pkg.sv
// nyakuo_pkg: shared types for the nyakuo core pipeline.
package nyakuo_pkg;
  localparam int XLEN = 32;
  typedef logic [4:0] reg_idx_t;
  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, LUI
  } instruction;
  localparam instruction NOP_INST = ADDI;
  typedef struct packed {
    instruction      inst;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    reg_idx_t        rd;
  } fetch_out_t;
endpackage

// File: rtl/operand_fetch_regfile.sv
// regfile: integer register file, two write-through read ports, one write port, x0 hardwired to zero.
module regfile #(
  parameter int XLEN = nyakuo_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  nyakuo_pkg::reg_idx_t ra1_i,
  input  nyakuo_pkg::reg_idx_t ra2_i,
  output logic [XLEN-1:0]      rd1_o,
  output logic [XLEN-1:0]      rd2_o,
  input  logic                 we_i,
  input  nyakuo_pkg::reg_idx_t wa_i,
  input  logic [XLEN-1:0]      wd_i
);
  logic [XLEN-1:0] mem_q [NREG];
  logic            wr;
  assign wr    = we_i && wa_i != '0;
  assign rd1_o = ra1_i == '0 ? '0 : (wr && wa_i == ra1_i) ? wd_i : mem_q[ra1_i];
  assign rd2_o = ra2_i == '0 ? '0 : (wr && wa_i == ra2_i) ? wd_i : mem_q[ra2_i];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with busy scoreboard, writeback bypass and a single-entry output slot.
module operand_fetch import nyakuo_pkg::*; #(
  parameter int XLEN = nyakuo_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  instruction      dec_inst_i,
  input  reg_idx_t        dec_rs1_i,
  input  reg_idx_t        dec_rs2_i,
  input  reg_idx_t        dec_rd_i,
  input  logic [XLEN-1:0] dec_imm_i,
  input  logic            dec_use_imm_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output instruction      ex_inst_o,
  output logic [XLEN-1:0] ex_operand_a_o,
  output logic [XLEN-1:0] ex_operand_b_o,
  output reg_idx_t        ex_rd_o,
  input  logic            wb_valid_i,
  input  reg_idx_t        wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};
  logic [NREG-1:0] busy_q, busy_d, clr, set, pend;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            valid_q, valid_d, hazard, accept;
  fetch_out_t      out_q, out_d;
  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1_i (dec_rs1_i),
    .ra2_i (dec_rs2_i),
    .rd1_o (rs1_val),
    .rd2_o (rs2_val),
    .we_i  (wb_valid_i),
    .wa_i  (wb_rd_i),
    .wd_i  (wb_data_i)
  );
  // A register cleared by writeback this cycle no longer blocks issue; its value is bypassed.
  always_comb begin
    clr         = wb_valid_i ? ONE << wb_rd_i : '0;
    pend        = busy_q & ~clr;
    hazard      = pend[dec_rs1_i] | (!dec_use_imm_i & pend[dec_rs2_i]) |
                  ((dec_rd_i != '0) & pend[dec_rd_i]);
    dec_ready_o = !rst_i && !flush_i && !hazard && (!valid_q || ex_ready_i);
    accept      = dec_valid_i && dec_ready_o;
    set         = (accept && dec_rd_i != '0) ? ONE << dec_rd_i : '0;
    busy_d      = flush_i ? '0 : (pend | set);
    valid_d     = flush_i ? 1'b0 : accept ? 1'b1 : ex_ready_i ? 1'b0 : valid_q;
    out_d       = accept ? '{inst:      dec_inst_i,
                             operand_a: rs1_val,
                             operand_b: dec_use_imm_i ? dec_imm_i : rs2_val,
                             rd:        dec_rd_i} : out_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '{inst: NOP_INST, operand_a: '0, operand_b: '0, rd: '0};
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end
  assign ex_valid_o     = valid_q;
  assign ex_inst_o      = out_q.inst;
  assign ex_operand_a_o = out_q.operand_a;
  assign ex_operand_b_o = out_q.operand_b;
  assign ex_rd_o        = out_q.rd;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed plus random stimulus checked against a register/scoreboard reference model.
module tb_operand_fetch;
  import nyakuo_pkg::*;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1, flush_i = 1'b0, dec_valid_i = 1'b0, dec_use_imm_i = 1'b0;
  logic        ex_ready_i = 1'b1, wb_valid_i = 1'b0;
  instruction  dec_inst_i = ADD;
  reg_idx_t    dec_rs1_i = '0, dec_rs2_i = '0, dec_rd_i = '0, wb_rd_i = '0;
  logic [31:0] dec_imm_i = '0, wb_data_i = '0;
  logic        dec_ready_o, ex_valid_o;
  instruction  ex_inst_o;
  logic [31:0] ex_operand_a_o, ex_operand_b_o;
  reg_idx_t    ex_rd_o;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] m_rf [32];
  bit   [31:0] m_busy;
  bit          m_v, last_acc, pending;
  instruction  m_inst;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;

  operand_fetch dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_inst_i(dec_inst_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_imm_i(dec_imm_i), .dec_use_imm_i(dec_use_imm_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_inst_o(ex_inst_o),
    .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o), .ex_rd_o(ex_rd_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rval(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_valid_i && wb_rd_i == r) return wb_data_i;
    return m_rf[r];
  endfunction

  function automatic bit still_busy(input logic [4:0] r);
    return m_busy[r] && !(wb_valid_i && wb_rd_i == r);
  endfunction

  // One cycle: inputs already driven; check ready, clock, update model, check slot.
  task automatic step();
    bit hz, rdy, acc;
    logic [31:0] a, b;
    #1;
    hz  = still_busy(dec_rs1_i) || (!dec_use_imm_i && still_busy(dec_rs2_i)) ||
          (dec_rd_i != 0 && still_busy(dec_rd_i));
    rdy = !rst_i && !flush_i && !hz && (!m_v || ex_ready_i);
    acc = dec_valid_i && rdy;
    check("dec_ready", dec_ready_o, rdy);
    a = rval(dec_rs1_i);
    b = dec_use_imm_i ? dec_imm_i : rval(dec_rs2_i);
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_busy = '0; m_v = 0; m_inst = ADDI; m_a = '0; m_b = '0; m_rd = '0;
      acc = 0;
    end else begin
      if (wb_valid_i && wb_rd_i != 0) m_rf[wb_rd_i] = wb_data_i;
      if (flush_i) begin
        m_busy = '0; m_v = 0;
      end else begin
        if (wb_valid_i) m_busy[wb_rd_i] = 0;
        if (acc && dec_rd_i != 0) m_busy[dec_rd_i] = 1;
        if (acc) begin
          m_v = 1; m_inst = dec_inst_i; m_a = a; m_b = b; m_rd = dec_rd_i;
        end else if (ex_ready_i) m_v = 0;
      end
    end
    last_acc = acc;
    #1;
    check("ex_valid", ex_valid_o, m_v);
    check("ex_inst", ex_inst_o, m_inst);
    check("ex_operand_a", ex_operand_a_o, m_a);
    check("ex_operand_b", ex_operand_b_o, m_b);
    check("ex_rd", ex_rd_o, m_rd);
  endtask

  task automatic issue(input instruction op, input logic [4:0] rd, rs1, rs2,
                       input logic [31:0] imm, input bit use_imm);
    dec_valid_i = 1; dec_inst_i = op; dec_rd_i = rd; dec_rs1_i = rs1;
    dec_rs2_i = rs2; dec_imm_i = imm; dec_use_imm_i = use_imm;
  endtask

  initial begin
    int r;
    @(posedge clk); #1;
    step(); step();
    rst_i = 0;
    step();
    issue(ADDI, 1, 0, 0, 5, 1); step();
    issue(ADD, 3, 1, 2, 0, 0); step();
    wb_valid_i = 1; wb_rd_i = 1; wb_data_i = 32'h1234; step();
    wb_valid_i = 0; dec_valid_i = 0; step();
    issue(SLLI, 4, 0, 0, 9, 1); step();
    issue(SLLI, 6, 3, 4, 31, 1); step();
    issue(ADDI, 5, 0, 0, 7, 1); ex_ready_i = 0; step();
    issue(ADD, 7, 0, 0, 0, 0); step();
    flush_i = 1; step();
    flush_i = 0; dec_valid_i = 0; ex_ready_i = 1; step();
    wb_valid_i = 1; wb_rd_i = 0; wb_data_i = 32'hdead; issue(ADD, 0, 0, 0, 0, 0); step();
    wb_valid_i = 0; issue(ADD, 2, 0, 0, 0, 0); step();
    dec_valid_i = 0; pending = 0;
    for (int c = 0; c < 3000; c++) begin
      if (last_acc) pending = 0;
      if (!pending && $urandom_range(0, 3) != 0) begin
        issue(instruction'(5'($urandom_range(0, 19))), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, 1'($urandom));
        pending = 1;
      end
      dec_valid_i = pending;
      ex_ready_i  = $urandom_range(0, 3) != 0;
      flush_i     = $urandom_range(0, 39) == 0;
      rst_i       = $urandom_range(0, 999) == 0;
      wb_valid_i  = $urandom_range(0, 9) < 4;
      r = $urandom_range(0, 7);
      for (int k = 0; k < 32; k++)
        if (m_busy[(r + k) % 32]) begin r = (r + k) % 32; break; end
      wb_rd_i   = 5'(r);
      wb_data_i = $urandom;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
